// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant identity
// and default bus widths.
package mips_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, hazard stalls and memory-side
// req/ack bus. The arbiter takes the slave view; the core/memory take master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = mips_mem_pkg::ADDR_W_DEF,
   parameter int DATA_W = mips_mem_pkg::DATA_W_DEF
);

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              stall_f;
   logic              stall_m;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              err;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output i_rdata, i_ready, d_rdata, d_ready, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata, err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  i_rdata, i_ready, d_rdata, d_ready, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata, err
   );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts memory wait cycles of the current transaction and flags expiry on the
// cycle that would exceed TIMEOUT_CYC outstanding mem_req cycles.
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int               CNT_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // cnt_q equals the number of un-acked mem_req cycles already elapsed
   assign expire_o = enable_i & (cnt_q == LAST_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable_i && (cnt_q != LAST_C)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and
// data ports, with registered memory requests, one-cycle ready pulses and a timeout.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   arb_state_t        state_q,     state_d;
   grant_t            last_q,      last_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              i_ready_q,   i_ready_d;
   logic              d_ready_q,   d_ready_d;
   logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              err_q,       err_d;

   logic i_elig_s;
   logic d_elig_s;
   logic wd_clear_s;
   logic wd_en_s;
   logic wd_expire_s;

   // A port in its ready cycle is not eligible, so it cannot be re-granted at once
   assign i_elig_s = bus.i_req & ~i_ready_q;
   assign d_elig_s = bus.d_req & ~d_ready_q;

   assign bus.stall_f   = i_elig_s;
   assign bus.stall_m   = d_elig_s;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ready   = i_ready_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.err       = err_q;

   assign wd_en_s = (state_q != IDLE) && !bus.mem_ack;

   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (wd_clear_s),
      .enable_i (wd_en_s),
      .expire_o (wd_expire_s)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      wd_clear_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_elig_s && (!i_elig_s || (last_q == GNT_I))) begin
               state_d     = SERVE_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               wd_clear_s  = 1'b1;
            end else if (i_elig_s) begin
               state_d     = SERVE_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.i_addr;
               wd_clear_s  = 1'b1;
            end else begin
               state_d     = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            // A timeout completes like an ack but returns zero data and sets err
            if (bus.mem_ack || wd_expire_s) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               err_d     = err_q | ~bus.mem_ack;
               if (state_q == SERVE_I) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
                  last_d    = GNT_I;
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
                  last_d    = GNT_D;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= GNT_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= {DATA_W{1'b0}};
         d_rdata_q   <= {DATA_W{1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requesters and a req/ack
// memory model, with a monitor popping expected memory requests and read data.
module tb_mem_port_arbiter;

   localparam int TO  = 12;
   localparam int LIM = 100;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wdata;
   } mreq_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   mreq_t       exp_m[$];
   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];

   int   ack_delay = 0;
   bit   hold_off  = 1'b0;
   bit   force_ack = 1'b0;
   int   wait_cnt  = 0;

   logic        prev_i   = 1'b0;
   logic        prev_d   = 1'b0;
   logic        prev_req = 1'b0;
   logic [31:0] hold_addr = 32'h0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h2002_0005;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic push_m(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic cw);
      mreq_t m;
      m.we = we; m.addr = a; m.wdata = wd; m.chk_wdata = cw;
      exp_m.push_back(m);
   endtask

   task automatic wait_i(input string name);
      int c = 0;
      do begin @(negedge clk); c++; end while (!bus.i_ready && c < LIM);
      chk(name, bus.i_ready, 1'b1);
   endtask

   task automatic wait_d(input string name);
      int c = 0;
      do begin @(negedge clk); c++; end while (!bus.d_ready && c < LIM);
      chk(name, bus.d_ready, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   // memory model: acks ack_delay cycles after mem_req rises
   initial begin : mem_model
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hBAD0_0BAD;
         end else if (bus.mem_req && !hold_off && !bus.mem_ack) begin
            if (wait_cnt >= ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               wait_cnt      = 0;
            end else begin
               bus.mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) wait_cnt = 0;
         end
      end
   end

   initial begin : monitor
      mreq_t m;
      forever begin
         @(negedge clk);
         chk("ready_exclusive", bus.i_ready & bus.d_ready, 1'b0);
         if (bus.i_ready) begin
            chk("i_exp_pending", exp_i.size() > 0, 1'b1);
            chk("i_ready_width", prev_i, 1'b0);
            if (exp_i.size() > 0) chk("i_rdata", bus.i_rdata, exp_i.pop_front());
         end
         if (bus.d_ready) begin
            chk("d_exp_pending", exp_d.size() > 0, 1'b1);
            chk("d_ready_width", prev_d, 1'b0);
            if (exp_d.size() > 0) chk("d_rdata", bus.d_rdata, exp_d.pop_front());
         end
         if (bus.mem_req && !prev_req) begin
            chk("mreq_exp_pending", exp_m.size() > 0, 1'b1);
            if (exp_m.size() > 0) begin
               m = exp_m.pop_front();
               chk("mem_we", bus.mem_we, m.we);
               chk("mem_addr", bus.mem_addr, m.addr);
               if (m.chk_wdata) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
            hold_addr = bus.mem_addr;
         end else if (bus.mem_req) begin
            chk("mem_addr_stable", bus.mem_addr, hold_addr);
         end
         prev_i   = bus.i_ready;
         prev_d   = bus.d_ready;
         prev_req = bus.mem_req;
      end
   end

   initial begin : global_guard
      #200000;
      $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "global time limit reached");
   end

   initial begin : stim
      int cnt;
      int c;
      int n;
      int got[3];
      logic err_early;

      reset = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      #1;
      chk("rst_mem_req",   bus.mem_req,   1'b0);
      chk("rst_mem_we",    bus.mem_we,    1'b0);
      chk("rst_mem_addr",  bus.mem_addr,  32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_ready",     {bus.i_ready, bus.d_ready, bus.err}, 3'b000);
      chk("rst_i_rdata",   bus.i_rdata,   32'h0);
      chk("rst_d_rdata",   bus.d_rdata,   32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: single fetch, ack two cycles after mem_req rises
      @(negedge clk);
      ack_delay = 2;
      push_m(1'b0, 32'h8, 32'h0, 1'b0);
      exp_i.push_back(32'h2002_0005);
      bus.i_req = 1'b1; bus.i_addr = 32'h8;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("t1_i_ready", bus.i_ready, (k == 4));
         chk("t1_mem_req", bus.mem_req, (k <= 3));
         if (k <= 4) chk("t1_stall_f", bus.stall_f, (k != 4));
         if (k == 4) bus.i_req = 1'b0;
      end

      // 2: simultaneous store and fetch after reset, data goes first
      do_reset();
      ack_delay = 0;
      push_m(1'b1, 32'h54, 32'h7, 1'b1);
      push_m(1'b0, 32'h10, 32'h0, 1'b0);
      exp_d.push_back(32'h0054_FFAB);
      exp_i.push_back(32'h0010_FFEF);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h54; bus.d_wdata = 32'h7;
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t2_mem_req", bus.mem_req, (k == 1) || (k == 3));
         chk("t2_d_ready", bus.d_ready, (k == 2));
         chk("t2_i_ready", bus.i_ready, (k == 4));
         if (k == 2) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
         if (k == 4) bus.i_req = 1'b0;
      end

      // 3: sustained conflict, grants alternate D,I,D,I,D,I
      ack_delay = 1;
      for (int k = 0; k < 3; k++) begin
         push_m(1'b0, 32'h200 + 32'(4 * k), 32'h0, 1'b0);
         push_m(1'b0, 32'h100 + 32'(4 * k), 32'h0, 1'b0);
      end
      exp_i.push_back(32'h0100_FEFF); exp_i.push_back(32'h0104_FEFB); exp_i.push_back(32'h0108_FEF7);
      exp_d.push_back(32'h0200_FDFF); exp_d.push_back(32'h0204_FDFB); exp_d.push_back(32'h0208_FDF7);
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               bus.i_req = 1'b1; bus.i_addr = 32'h100 + 32'(4 * k);
               wait_i("t3_i_done");
            end
            bus.i_req = 1'b0;
         end
         begin
            for (int k = 0; k < 3; k++) begin
               bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200 + 32'(4 * k);
               wait_d("t3_d_done");
            end
            bus.d_req = 1'b0;
         end
      join

      // 4: load never acked, watchdog aborts
      hold_off = 1'b1;
      push_m(1'b0, 32'h300, 32'h0, 1'b0);
      exp_d.push_back(32'h0);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
      cnt = 0; c = 0; err_early = 1'b0;
      do begin
         @(negedge clk); c++;
         if (bus.mem_req) begin cnt++; err_early = err_early | bus.err; end
      end while (!bus.d_ready && c < LIM);
      chk("t4_d_ready", bus.d_ready, 1'b1);
      chk("t4_req_cycles", cnt, TO);
      chk("t4_err_early", err_early, 1'b0);
      chk("t4_err_set", bus.err, 1'b1);
      bus.d_req = 1'b0;
      force_ack = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t4_late_ack_ignored", {bus.mem_req, bus.i_ready, bus.d_ready, bus.err}, 4'b0001);
         if (k == 2) force_ack = 1'b0;
      end
      hold_off = 1'b0; ack_delay = 0;
      push_m(1'b0, 32'h20, 32'h0, 1'b0);
      exp_i.push_back(32'h0020_FFDF);
      bus.i_req = 1'b1; bus.i_addr = 32'h20;
      wait_i("t4_fetch_after_abort");
      bus.i_req = 1'b0;
      chk("t4_err_sticky", bus.err, 1'b1);

      // 5: asynchronous reset in the middle of a store
      hold_off = 1'b1;
      push_m(1'b1, 32'h400, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400; bus.d_wdata = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      chk("t5_busy", {bus.mem_req, bus.mem_we, bus.err}, 3'b111);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_clear", {bus.mem_req, bus.mem_we, bus.i_ready, bus.d_ready, bus.err}, 5'b00000);
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      #1 reset = 1'b0;
      hold_off = 1'b0; ack_delay = 0;
      @(negedge clk);
      push_m(1'b0, 32'h600, 32'h0, 1'b0);
      exp_i.push_back(32'h0600_F9FF);
      bus.i_req = 1'b1; bus.i_addr = 32'h600;
      c = 0;
      do begin @(negedge clk); c++; end while (!bus.i_ready && c < LIM);
      chk("t5_next_latency", c, 2);
      bus.i_req = 1'b0;

      // 6: back-to-back fetches with an always-ready memory
      for (int k = 0; k < 3; k++) begin
         push_m(1'b0, 32'h500 + 32'(4 * k), 32'h0, 1'b0);
         got[k] = 0;
      end
      exp_i.push_back(32'h0500_FAFF); exp_i.push_back(32'h0504_FAFB); exp_i.push_back(32'h0508_FAF7);
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 32'h500;
      n = 0; c = 0;
      while (n < 3 && c < 40) begin
         @(negedge clk); c++;
         if (bus.i_ready) begin
            got[n] = c; n++;
            if (n < 3) bus.i_addr = 32'h500 + 32'(4 * n);
            else bus.i_req = 1'b0;
         end
      end
      chk("t6_ready_1", got[0], 2);
      chk("t6_ready_2", got[1], 5);
      chk("t6_ready_3", got[2], 8);

      repeat (3) @(negedge clk);
      chk("drain_exp_i", exp_i.size(), 0);
      chk("drain_exp_d", exp_d.size(), 0);
      chk("drain_exp_m", exp_m.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
